// File: rtl/lsc_pkg.sv
// Shared types for the local store controller: FSM state encoding and skid depth.
package lsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } lsc_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/lsc_skid_buffer.sv
// Two-entry (data, last) FIFO that absorbs SRAM read latency and PE backpressure.
// The head entry drives the PE port directly, so it only moves on an accepted beat.
module lsc_skid_buffer
    import lsc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   count
);

    logic [W:0] entry_q [SKID_DEPTH];
    logic       rptr_q;
    logic       wptr_q;
    logic [1:0] count_q;
    logic       pop;

    assign pop       = (count_q != 2'd0) && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = entry_q[rptr_q][W-1:0];
    assign out_last  = out_valid && entry_q[rptr_q][W];
    assign count     = count_q;

    // Entry storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                entry_q[wptr_q] <= {push_last, push_data};
                wptr_q          <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/local_store_controller.sv
// Local store sequencer: FILL streams upstream words into the SRAM, READ replays a
// strided window to the PE cfg_repeat times through a two-entry skid buffer.
//
//   state | meaning
//   IDLE  | waiting for cfg_start; cfg fields latched on acceptance
//   FILL  | in_ready high, one SRAM write per upstream handshake
//   READ  | issuing strided reads, draining words to the PE
//   DONE  | one-cycle done pulse, busy low, back to IDLE
module local_store_controller
    import lsc_pkg::*;
#(
    parameter int A     = 7,
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             cfg_start,
    input  logic             cfg_fill,
    input  logic [A-1:0]     cfg_base,
    input  logic [A:0]       cfg_len,
    input  logic [A-1:0]     cfg_stride,
    input  logic [CNT_W-1:0] cfg_repeat,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [A-1:0]     mem_addr,
    output logic [W-1:0]     mem_wdata,
    output logic             mem_write,
    input  logic [W-1:0]     mem_rdata,
    output logic             busy,
    output logic             done
);

    localparam logic [A:0]       IDX_ONE  = {{A{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PASS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    lsc_state_e       state_q, state_d;

    logic [A-1:0]     base_q;
    logic [A-1:0]     stride_q;
    logic [A:0]       len_q;
    logic [CNT_W-1:0] repeat_q;

    logic [A:0]       widx_q;
    logic [A:0]       ridx_q;
    logic [CNT_W-1:0] pass_q;
    logic [A-1:0]     raddr_q;
    logic [A-1:0]     addr_q;
    logic             inflight_q;
    logic             inflight_last_q;
    logic             reads_done_q;

    logic [1:0]       skid_count;
    logic [1:0]       occ_next;
    logic             start_acc;
    logic             fill_last;
    logic             rd_wrap;
    logic             rd_final;
    logic             rd_en;
    logic             pop;
    logic [A-1:0]     wr_addr;

    assign start_acc = (state_q == IDLE) && cfg_start;
    assign wr_addr   = base_q + widx_q[A-1:0];
    assign fill_last = (widx_q == len_q - IDX_ONE);
    assign rd_wrap   = (ridx_q == len_q - IDX_ONE);
    assign rd_final  = rd_wrap && (pass_q == repeat_q - PASS_ONE);
    assign pop       = out_valid && out_ready;

    // Occupancy as it will stand next cycle: counting the beat leaving now is what
    // lets a read issue every cycle while the PE keeps out_ready high.
    assign occ_next  = skid_count - {1'b0, pop} + {1'b0, inflight_q};
    assign rd_en     = (state_q == READ) && !reads_done_q && (occ_next < 2'(SKID_DEPTH));

    assign mem_wdata = mem_write ? in_data : '0;
    assign mem_addr  = mem_write ? wr_addr : (rd_en ? raddr_q : addr_q);

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_fill && (cfg_len != '0)) begin
                        state_d = FILL;
                    end else if ((cfg_repeat != '0) && (cfg_len != '0)) begin
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
                mem_write = in_valid;
                if (in_valid && fill_last) begin
                    state_d = (repeat_q != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy = 1'b1;
                if (pop && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job configuration, write/read indices, pass counter and read-in-flight tracking.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            base_q          <= '0;
            stride_q        <= '0;
            len_q           <= '0;
            repeat_q        <= '0;
            widx_q          <= '0;
            ridx_q          <= '0;
            pass_q          <= '0;
            raddr_q         <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            reads_done_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                base_q       <= cfg_base;
                stride_q     <= cfg_stride;
                len_q        <= cfg_len;
                repeat_q     <= cfg_repeat;
                widx_q       <= '0;
                ridx_q       <= '0;
                pass_q       <= '0;
                raddr_q      <= cfg_base;
                reads_done_q <= 1'b0;
            end
            if (mem_write) begin
                widx_q <= widx_q + IDX_ONE;
            end
            if (rd_en) begin
                if (rd_wrap) begin
                    ridx_q  <= '0;
                    pass_q  <= pass_q + PASS_ONE;
                    raddr_q <= base_q;
                end else begin
                    ridx_q  <= ridx_q + IDX_ONE;
                    raddr_q <= raddr_q + stride_q;
                end
                if (rd_final) begin
                    reads_done_q <= 1'b1;
                end
            end
            if (mem_write || rd_en) begin
                addr_q <= mem_addr;
            end
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_final;
        end
    end

    lsc_skid_buffer #(.W(W)) u_skid (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .push_last (inflight_last_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_local_store_controller.sv
// Bench for local_store_controller: SRAM model, randomized upstream/PE handshakes,
// and a job-level reference model (expected write list and beat list per job).
module tb_local_store_controller;

    localparam int A     = 7;
    localparam int W     = 16;
    localparam int CNT_W = 8;
    localparam int DEPTH = 1 << A;

    logic             CLK = 1'b0;
    logic             RESETn = 1'b0;
    logic             cfg_start = 1'b0;
    logic             cfg_fill = 1'b0;
    logic [A-1:0]     cfg_base = '0;
    logic [A:0]       cfg_len = '0;
    logic [A-1:0]     cfg_stride = '0;
    logic [CNT_W-1:0] cfg_repeat = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [A-1:0]     mem_addr;
    logic [W-1:0]     mem_wdata;
    logic             mem_write;
    logic [W-1:0]     mem_rdata = '0;
    logic             busy;
    logic             done;

    local_store_controller #(.A(A), .W(W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .cfg_start  (cfg_start),
        .cfg_fill   (cfg_fill),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_stride (cfg_stride),
        .cfg_repeat (cfg_repeat),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // SRAM with one-cycle read latency; preload fills it with 0x1000 + address.
    logic [W-1:0] sram [DEPTH];
    bit           do_preload = 1'b0;
    always @(posedge CLK) begin
        if (do_preload) begin
            for (int a = 0; a < DEPTH; a++) sram[a] <= W'(16'h1000 + a);
        end else begin
            if (mem_write) sram[mem_addr] <= mem_wdata;
            mem_rdata <= sram[mem_addr];
        end
    end

    // Reference model state.
    logic [W-1:0] ref_mem [DEPTH];
    int           exp_wa[$];
    logic [W-1:0] exp_wd[$];
    logic [W-1:0] exp_bd[$];
    bit           exp_bl[$];
    logic [W-1:0] feed_q[$];
    int           got_wa[$];
    logic [W-1:0] got_wd[$];
    logic [W-1:0] got_bd[$];
    bit           got_bl[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit job_on = 1'b0, done_seen = 1'b0, j_fill = 1'b0, j_read = 1'b0;
    int j_total, start_cyc, first_valid_cyc, last_write_cyc, last_beat_cyc, done_cyc;
    int beats_seen, valid_cycles;
    int valid_pct = 100, ready_pct = 100;

    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    task automatic check(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model's expected write and beat sequences.
    always @(negedge CLK) begin
        if (!RESETn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall holds out_valid", out_valid, 1);
                check("stall holds out_data", out_data, prev_data);
                check("stall holds out_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            if (mem_write) begin
                check("write needs handshake", in_valid && in_ready, 1);
                if (exp_wa.size() == 0) begin
                    check("unexpected write", 1, 0);
                end else begin
                    check("write addr", mem_addr, exp_wa.pop_front());
                    check("write data", mem_wdata, exp_wd.pop_front());
                end
                got_wa.push_back(int'(mem_addr));
                got_wd.push_back(mem_wdata);
                last_write_cyc = cyc;
            end

            if (out_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end

            if (out_valid && out_ready) begin
                if (exp_bd.size() == 0) begin
                    check("unexpected beat", 1, 0);
                end else begin
                    check("beat data", out_data, exp_bd.pop_front());
                    check("beat last", out_last, exp_bl.pop_front());
                end
                got_bd.push_back(out_data);
                got_bl.push_back(out_last);
                beats_seen++;
                last_beat_cyc = cyc;
            end

            if (done) begin
                if (!job_on) begin
                    check("done outside a job", 1, 0);
                end else begin
                    check("busy low with done", busy, 0);
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                    job_on    = 1'b0;
                end
            end else if (job_on && cyc > start_cyc) begin
                check("busy during job", busy, 1);
            end
        end
    end

    // Upstream source: presents the head of feed_q with random valid gaps.
    initial begin
        forever begin
            @(negedge CLK);
            if (in_valid && in_ready && feed_q.size() > 0) void'(feed_q.pop_front());
            @(posedge CLK);
            #1;
            if (feed_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
                in_valid = 1'b1;
                in_data  = feed_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end
        end
    end

    // PE sink: random out_ready at the configured rate.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    task automatic start_job(input bit fill, input int base, input int len, input int stride,
                             input int rep, input int vpct, input int rpct, input bit seq_data);
        logic [W-1:0] d;
        int           a;
        j_fill  = fill && (len != 0);
        j_read  = (rep != 0) && (len != 0);
        j_total = j_read ? rep * len : 0;
        exp_wa.delete(); exp_wd.delete(); exp_bd.delete(); exp_bl.delete(); feed_q.delete();
        got_wa.delete(); got_wd.delete(); got_bd.delete(); got_bl.delete();
        if (j_fill) begin
            for (int i = 0; i < len; i++) begin
                d = seq_data ? W'(16'h00A0 + i) : W'($urandom);
                a = (base + i) % DEPTH;
                exp_wa.push_back(a);
                exp_wd.push_back(d);
                ref_mem[a] = d;
                feed_q.push_back(d);
            end
        end
        if (j_read) begin
            for (int p = 0; p < rep; p++) begin
                for (int i = 0; i < len; i++) begin
                    a = (base + i * stride) % DEPTH;
                    exp_bd.push_back(ref_mem[a]);
                    exp_bl.push_back((p == rep - 1) && (i == len - 1));
                end
            end
        end
        first_valid_cyc = -1;
        last_write_cyc  = -1;
        last_beat_cyc   = -1;
        done_cyc        = -1;
        beats_seen      = 0;
        valid_cycles    = 0;
        valid_pct       = vpct;
        ready_pct       = rpct;
        @(posedge CLK);
        #1;
        cfg_fill   = fill;
        cfg_base   = A'(base);
        cfg_len    = (A+1)'(len);
        cfg_stride = A'(stride);
        cfg_repeat = CNT_W'(rep);
        cfg_start  = 1'b1;
        start_cyc  = cyc;
        done_seen  = 1'b0;
        job_on     = 1'b1;
        @(posedge CLK);
        #1;
        cfg_start  = 1'b0;
        cfg_fill   = 1'($urandom);
        cfg_base   = A'($urandom);
        cfg_len    = (A+1)'($urandom);
        cfg_stride = A'($urandom);
        cfg_repeat = CNT_W'($urandom);
    endtask

    task automatic finish_job(input string tag);
        int g = 0;
        int evt, entry;
        while (!done_seen && g < 9000) begin
            @(negedge CLK);
            #1;
            g++;
        end
        check({tag, " done seen"}, done_seen, 1);
        if (!done_seen) job_on = 1'b0;
        check({tag, " writes left"}, exp_wa.size(), 0);
        check({tag, " beats left"}, exp_bd.size(), 0);
        if (j_read) begin
            evt   = last_beat_cyc;
            entry = j_fill ? last_write_cyc + 1 : start_cyc + 1;
            check({tag, " first out_valid latency"}, first_valid_cyc - entry, 2);
            if (ready_pct == 100)
                check({tag, " back-to-back beats"}, last_beat_cyc - first_valid_cyc, j_total - 1);
        end else begin
            evt = j_fill ? last_write_cyc : start_cyc;
            check({tag, " no out_valid"}, valid_cycles, 0);
        end
        check({tag, " done cycle"}, done_cyc, evt + 1);
        @(negedge CLK);
        #1;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " busy after done"}, busy, 0);
    endtask

    task automatic run_job(input string tag, input bit fill, input int base, input int len,
                           input int stride, input int rep, input int vpct, input int rpct,
                           input bit seq_data);
        start_job(fill, base, len, stride, rep, vpct, rpct, seq_data);
        finish_job(tag);
    endtask

    initial begin
        logic [W-1:0] e3 [6];
        int           g, r, len;

        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] e2 [4];
        logic [W-1:0] e3 [6];
        int           g, r, len;

        e2 = '{16'h107E, 16'h107F, 16'h1000, 16'h1001};
        // mem[8] was overwritten by the fill-only job with 0x00A3.
        e3 = '{16'h1000, 16'h1004, 16'h00A3, 16'h1000, 16'h1004, 16'h00A3};

        repeat (3) @(posedge CLK);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_write", mem_write, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);

        for (int a = 0; a < DEPTH; a++) ref_mem[a] = W'(16'h1000 + a);
        do_preload = 1'b1;
        @(posedge CLK);
        #1;
        do_preload = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;

        // Fill only.
        run_job("fill", 1'b1, 5, 4, 1, 0, 100, 100, 1'b1);
        check("fill write count", got_wa.size(), 4);
        if (got_wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("fill literal addr", got_wa[i], 5 + i);
                check("fill literal data", got_wd[i], 16'h00A0 + i);
            end
        end
        check("fill done after 4th write", done_cyc - last_write_cyc, 1);

        // Address wrap-around.
        run_job("wrap", 1'b0, 126, 4, 1, 1, 100, 100, 1'b0);
        check("wrap beat count", got_bd.size(), 4);
        if (got_bd.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("wrap literal data", got_bd[i], e2[i]);
                check("wrap literal last", got_bl[i], (i == 3) ? 1 : 0);
            end
        end

        // Stride and repeat, first with free flow then with backpressure.
        for (int k = 0; k < 2; k++) begin
            run_job(k == 0 ? "stride" : "stride bp", 1'b0, 0, 3, 4, 2, 100, k == 0 ? 100 : 50, 1'b0);
            check("stride beat count", got_bd.size(), 6);
            if (got_bd.size() == 6) begin
                for (int i = 0; i < 6; i++) begin
                    check("stride literal data", got_bd[i], e3[i]);
                    check("stride literal last", got_bl[i], (i == 5) ? 1 : 0);
                end
            end
        end

        // Degenerate jobs.
        run_job("len0", 1'b1, 10, 0, 1, 3, 100, 100, 1'b0);
        check("len0 no writes", got_wa.size(), 0);
        check("len0 done 1 after start", done_cyc - start_cyc, 1);
        run_job("rep0 nofill", 1'b0, 20, 5, 1, 0, 100, 100, 1'b0);
        check("rep0 no writes", got_wa.size(), 0);
        check("rep0 done 1 after start", done_cyc - start_cyc, 1);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            r   = int'($urandom_range(9));
            len = (r == 0) ? 0 : (r == 9) ? DEPTH : int'($urandom_range(1, 12));
            run_job("random", 1'($urandom), int'($urandom_range(DEPTH - 1)), len,
                    int'($urandom_range(DEPTH - 1)), int'($urandom_range(0, 2)),
                    int'($urandom_range(30, 100)),
                    (j % 4 == 0) ? 100 : int'($urandom_range(30, 100)), 1'b0);
        end

        // Reset in the middle of READ, then a fresh job.
        start_job(1'b0, 0, 20, 3, 3, 100, 100, 1'b0);
        g = 0;
        while (beats_seen < 2 && g < 200) begin
            @(negedge CLK);
            #1;
            g++;
        end
        check("abort reached beat 2", beats_seen, 2);
        @(posedge CLK);
        #2;
        RESETn = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort mem_write", mem_write, 0);
        check("abort done", done, 0);
        job_on = 1'b0;
        exp_wa.delete(); exp_wd.delete(); exp_bd.delete(); exp_bl.delete(); feed_q.delete();
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        repeat (4) @(negedge CLK);
        #1;
        check("abort no done pulse", done_seen, 0);
        run_job("after reset", 1'b1, 100, 6, 5, 2, 70, 60, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
